fire_sequencer: RTL and testbench

FIRE_SEQUENCER -- requirements
Module: fire_sequencer

---
 rtl/fire_sequencer_if.sv | 25 ++
 rtl/fire_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fire_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire_sequencer_if.sv
// rtl/fire_sequencer_if.sv - request/status and PWM-facing signal bundle for fire_sequencer
interface fire_sequencer_if;
   logic        fire_req;
   logic        abort;
   logic [31:0] target_angle;
   logic [31:0] target_velocity;
   logic [31:0] angle_out;
   logic [31:0] velocity_out;
   logic        shoot_enable;
   logic        fire_ack;
   logic        done;
   logic        aborted;
   logic        busy;
   logic [2:0]  state;

   modport master (
      output fire_req, abort, target_angle, target_velocity,
      input  angle_out, velocity_out, shoot_enable, fire_ack, done, aborted, busy, state
   );

   modport slave (
      input  fire_req, abort, target_angle, target_velocity,
      output angle_out, velocity_out, shoot_enable, fire_ack, done, aborted, busy, state
   );
endinterface

// File: rtl/fire_sequencer.sv
// rtl/fire_sequencer.sv - turret fire sequencer: aim, spin up, fire, cool down
module fire_sequencer #(
   parameter int unsigned SETTLE_CYCLES   = 25000000,
   parameter int unsigned SPINUP_CYCLES   = 50000000,
   parameter int unsigned FIRE_CYCLES     = 25000000,
   parameter int unsigned COOLDOWN_CYCLES = 50000000
) (
   input  logic            clock,
   input  logic            reset_n,
   fire_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_AIM      = 3'd1,
      S_SPINUP   = 3'd2,
      S_FIRE     = 3'd3,
      S_COOLDOWN = 3'd4
   } state_t;

   // A zero-length phase still occupies one clock, so the last count is clamped at 0.
   localparam logic [31:0] SETTLE_LAST   = (SETTLE_CYCLES   == 0) ? 32'd0 : 32'(SETTLE_CYCLES   - 1);
   localparam logic [31:0] SPINUP_LAST   = (SPINUP_CYCLES   == 0) ? 32'd0 : 32'(SPINUP_CYCLES   - 1);
   localparam logic [31:0] FIRE_LAST     = (FIRE_CYCLES     == 0) ? 32'd0 : 32'(FIRE_CYCLES     - 1);
   localparam logic [31:0] COOLDOWN_LAST = (COOLDOWN_CYCLES == 0) ? 32'd0 : 32'(COOLDOWN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] angle_q, angle_d;
   logic [31:0] vel_latch_q, vel_latch_d;
   logic [31:0] vel_out_q, vel_out_d;
   logic        shoot_q, shoot_d;
   logic        ack_q, ack_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;
   logic        abort_seen_q, abort_seen_d;
   logic [31:0] phase_last;
   logic        phase_end;
   logic        abortable;

   always_comb begin
      phase_last = 32'd0;
      case (state_q)
         S_AIM:      phase_last = SETTLE_LAST;
         S_SPINUP:   phase_last = SPINUP_LAST;
         S_FIRE:     phase_last = FIRE_LAST;
         S_COOLDOWN: phase_last = COOLDOWN_LAST;
         default:    phase_last = 32'd0;
      endcase
   end

   assign phase_end = (cnt_q == phase_last);
   assign abortable = (state_q == S_AIM) || (state_q == S_SPINUP) || (state_q == S_FIRE);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 32'd1;
      angle_d      = angle_q;
      vel_latch_d  = vel_latch_q;
      vel_out_d    = vel_out_q;
      shoot_d      = 1'b0;
      ack_d        = 1'b0;
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      abort_seen_d = abort_seen_q;

      // Abort is checked ahead of the phase timers so it wins a same-edge timeout.
      if (abortable && bus.abort) begin
         state_d      = S_COOLDOWN;
         cnt_d        = 32'd0;
         vel_out_d    = 32'd0;
         aborted_d    = 1'b1;
         abort_seen_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_d     = 32'd0;
               vel_out_d = 32'd0;
               if (bus.fire_req && !bus.abort) begin
                  state_d      = S_AIM;
                  angle_d      = bus.target_angle;
                  vel_latch_d  = bus.target_velocity;
                  ack_d        = 1'b1;
                  abort_seen_d = 1'b0;
               end
            end
            S_AIM: begin
               if (phase_end) begin
                  state_d   = S_SPINUP;
                  cnt_d     = 32'd0;
                  vel_out_d = vel_latch_q;
               end
            end
            S_SPINUP: begin
               if (phase_end) begin
                  state_d = S_FIRE;
                  cnt_d   = 32'd0;
                  shoot_d = 1'b1;
               end
            end
            S_FIRE: begin
               if (phase_end) begin
                  state_d   = S_COOLDOWN;
                  cnt_d     = 32'd0;
                  vel_out_d = 32'd0;
               end else begin
                  shoot_d = 1'b1;
               end
            end
            S_COOLDOWN: begin
               if (phase_end) begin
                  state_d = S_IDLE;
                  cnt_d   = 32'd0;
                  done_d  = !abort_seen_q;
               end
            end
            default: begin
               // Corrupted state code: fall back to a fully reset IDLE.
               state_d      = S_IDLE;
               cnt_d        = 32'd0;
               angle_d      = 32'd0;
               vel_latch_d  = 32'd0;
               vel_out_d    = 32'd0;
               abort_seen_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 32'd0;
         angle_q      <= 32'd0;
         vel_latch_q  <= 32'd0;
         vel_out_q    <= 32'd0;
         shoot_q      <= 1'b0;
         ack_q        <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         angle_q      <= angle_d;
         vel_latch_q  <= vel_latch_d;
         vel_out_q    <= vel_out_d;
         shoot_q      <= shoot_d;
         ack_q        <= ack_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         abort_seen_q <= abort_seen_d;
      end
   end

   assign bus.angle_out    = angle_q;
   assign bus.velocity_out = vel_out_q;
   assign bus.shoot_enable = shoot_q;
   assign bus.fire_ack     = ack_q;
   assign bus.done         = done_q;
   assign bus.aborted      = aborted_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.state        = state_q;

endmodule

// File: tb/tb_fire_sequencer.sv
// tb/tb_fire_sequencer.sv - self-checking bench for fire_sequencer
module tb_fire_sequencer;
   localparam int S = 4, P = 3, F = 2, C = 5;
   localparam int SL = (S < 1) ? 1 : S;
   localparam int PL = (P < 1) ? 1 : P;
   localparam int FL = (F < 1) ? 1 : F;
   localparam int CL = (C < 1) ? 1 : C;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   fire_sequencer_if bus();
   fire_sequencer_if bz();

   fire_sequencer #(.SETTLE_CYCLES(S), .SPINUP_CYCLES(P), .FIRE_CYCLES(F), .COOLDOWN_CYCLES(C))
      u_dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

   fire_sequencer #(.SETTLE_CYCLES(0), .SPINUP_CYCLES(0), .FIRE_CYCLES(0), .COOLDOWN_CYCLES(0))
      u_zero (.clock(clock), .reset_n(reset_n), .bus(bz.slave));

   int n_checks = 0;
   int n_pass = 0;

   typedef struct packed {
      logic        fr;
      logic        ab;
      logic [31:0] ang;
      logic [31:0] vel;
      logic [2:0]  st;
      logic        ack;
      logic        dn;
      logic        abo;
      logic        sh;
      logic [31:0] vo;
      logic [31:0] ao;
   } vec_t;

   vec_t vec [16];

   function automatic vec_t mk(logic fr, logic ab, int ang, int vel, int st,
                               logic ack, logic dn, logic abo, logic sh, int vo, int ao);
      vec_t v;
      v.fr = fr; v.ab = ab; v.ang = 32'(ang); v.vel = 32'(vel); v.st = 3'(st);
      v.ack = ack; v.dn = dn; v.abo = abo; v.sh = sh; v.vo = 32'(vo); v.ao = 32'(ao);
      return v;
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      bus.fire_req = 1'b0; bus.abort = 1'b0; bus.target_angle = 32'd0; bus.target_velocity = 32'd0;
      bz.fire_req = 1'b0;  bz.abort = 1'b0;  bz.target_angle = 32'd0;  bz.target_velocity = 32'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Behavioural model: the sequence is a timeline indexed by cycles since the ack.
   int          m_k, m_cool_at;
   bit          m_idle, m_abflag;
   logic [31:0] m_ang, m_vel;

   function automatic int phase_of(int kk);
      if (kk >= m_cool_at) return 4;
      if (kk < SL) return 1;
      if (kk < SL + PL) return 2;
      return 3;
   endfunction

   initial begin
      int          ack_cnt, ack2, ab_cnt, dn_cnt, sh_cnt, ph;
      logic [7:0]  sh_mask, dn_mask;
      logic        fr, ab, e_ack, e_done, e_ab, e_sh;
      logic [31:0] ta, tv, e_vo;
      logic [2:0]  e_st;

      vec[0]  = mk(1, 0, 90, 200, 1, 1, 0, 0, 0, 0,   90);
      vec[1]  = mk(0, 0, 90, 200, 1, 0, 0, 0, 0, 0,   90);
      vec[2]  = mk(0, 0, 45, 999, 1, 0, 0, 0, 0, 0,   90);
      vec[3]  = mk(0, 0, 45, 999, 1, 0, 0, 0, 0, 0,   90);
      vec[4]  = mk(0, 0, 45, 999, 2, 0, 0, 0, 0, 200, 90);
      vec[5]  = mk(1, 0, 45, 999, 2, 0, 0, 0, 0, 200, 90);
      vec[6]  = mk(0, 0, 0,  0,   2, 0, 0, 0, 0, 200, 90);
      vec[7]  = mk(0, 0, 0,  0,   3, 0, 0, 0, 1, 200, 90);
      vec[8]  = mk(0, 0, 0,  0,   3, 0, 0, 0, 1, 200, 90);
      vec[9]  = mk(0, 0, 0,  0,   4, 0, 0, 0, 0, 0,   90);
      vec[10] = mk(0, 1, 0,  0,   4, 0, 0, 0, 0, 0,   90);
      vec[11] = mk(0, 0, 0,  0,   4, 0, 0, 0, 0, 0,   90);
      vec[12] = mk(0, 0, 0,  0,   4, 0, 0, 0, 0, 0,   90);
      vec[13] = mk(0, 0, 0,  0,   4, 0, 0, 0, 0, 0,   90);
      vec[14] = mk(0, 0, 0,  0,   0, 0, 1, 0, 0, 0,   90);
      vec[15] = mk(0, 0, 0,  0,   0, 0, 0, 0, 0, 0,   90);

      // Reset state
      idle_inputs();
      step();
      check("reset_state", bus.state, 0);
      check("reset_outs", {bus.busy, bus.shoot_enable, bus.fire_ack, bus.done, bus.aborted,
                           bus.velocity_out, bus.angle_out}, 0);

      // Single fire, table driven
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.fire_req = vec[i].fr; bus.abort = vec[i].ab;
         bus.target_angle = vec[i].ang; bus.target_velocity = vec[i].vel;
         step();
         check($sformatf("tbl[%0d].state", i), bus.state, vec[i].st);
         check($sformatf("tbl[%0d].busy", i), bus.busy, (vec[i].st != 0));
         check($sformatf("tbl[%0d].ack", i), bus.fire_ack, vec[i].ack);
         check($sformatf("tbl[%0d].done", i), bus.done, vec[i].dn);
         check($sformatf("tbl[%0d].aborted", i), bus.aborted, vec[i].abo);
         check($sformatf("tbl[%0d].shoot", i), bus.shoot_enable, vec[i].sh);
         check($sformatf("tbl[%0d].vel", i), bus.velocity_out, vec[i].vo);
         check($sformatf("tbl[%0d].angle", i), bus.angle_out, vec[i].ao);
      end

      // Abort sampled at the end of c5 (SPINUP)
      do_reset();
      ab_cnt = 0; dn_cnt = 0; sh_cnt = 0;
      for (int c = 0; c < 14; c++) begin
         bus.fire_req = (c == 0); bus.abort = (c == 6);
         bus.target_angle = 32'd10; bus.target_velocity = 32'd300;
         step();
         if (bus.aborted) ab_cnt++;
         if (bus.done) dn_cnt++;
         if (bus.shoot_enable) sh_cnt++;
         if (c == 6) begin
            check("abort_c6_state", bus.state, 4);
            check("abort_c6_pulse", bus.aborted, 1);
            check("abort_c6_vel", bus.velocity_out, 0);
         end
         if (c == 10) check("abort_c10_still_cool", bus.state, 4);
         if (c == 11) check("abort_c11_idle", bus.state, 0);
      end
      check("abort_pulse_count", ab_cnt, 1);
      check("abort_no_done", dn_cnt, 0);
      check("abort_no_shoot", sh_cnt, 0);

      // fire_req held high; angle changes mid-sequence
      do_reset();
      ack_cnt = 0; ack2 = -1;
      for (int c = 0; c < 18; c++) begin
         bus.fire_req = 1'b1; bus.abort = 1'b0;
         bus.target_angle = (c >= 3) ? 32'd77 : 32'd90;
         bus.target_velocity = 32'd200;
         step();
         if (bus.fire_ack) begin
            ack_cnt++;
            if (c != 0) ack2 = c;
         end
         if (c == 0) check("held_ack_c0", bus.fire_ack, 1);
         if (c == 14) check("held_angle_c14", bus.angle_out, 90);
         if (c == 14) check("held_done_c14", bus.done, 1);
      end
      check("held_ack_count", ack_cnt, 2);
      check("held_second_ack_cycle", ack2, 15);
      check("held_angle_after", bus.angle_out, 77);

      // Reset asserted during FIRE
      do_reset();
      for (int c = 0; c < 9; c++) begin
         bus.fire_req = (c == 0); bus.target_angle = 32'd33; bus.target_velocity = 32'd120;
         step();
      end
      check("rst_pre_shoot", bus.shoot_enable, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_async_shoot", bus.shoot_enable, 0);
      check("rst_async_vel", bus.velocity_out, 0);
      check("rst_async_state", bus.state, 0);
      check("rst_async_angle", bus.angle_out, 0);
      @(negedge clock);
      idle_inputs();
      step();
      reset_n = 1'b1;
      dn_cnt = 0; ab_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.done) dn_cnt++;
         if (bus.aborted) ab_cnt++;
      end
      check("rst_no_done", dn_cnt, 0);
      check("rst_no_aborted", ab_cnt, 0);

      // All-zero phase lengths
      do_reset();
      sh_mask = '0; dn_mask = '0;
      for (int c = 0; c < 8; c++) begin
         bz.fire_req = (c == 0); bz.target_angle = 32'd5; bz.target_velocity = 32'd6;
         step();
         sh_mask[c] = bz.shoot_enable;
         dn_mask[c] = bz.done;
      end
      check("zero_shoot_mask", sh_mask, 8'b0000_0100);
      check("zero_done_mask", dn_mask, 8'b0001_0000);

      // abort together with fire_req in IDLE
      do_reset();
      ack_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         bus.fire_req = 1'b1; bus.abort = 1'b1; bus.target_angle = 32'd1;
         step();
         if (bus.fire_ack) ack_cnt++;
         check("abort_fire_idle_state", bus.state, 0);
      end
      check("abort_fire_idle_noack", ack_cnt, 0);

      // Randomised run against the timeline model
      do_reset();
      m_idle = 1; m_abflag = 0; m_k = 0; m_cool_at = 0; m_ang = 32'd0; m_vel = 32'd0;
      for (int n = 0; n < 1500; n++) begin
         fr = ($urandom_range(0, 2) == 0);
         ab = ($urandom_range(0, 19) == 0);
         ta = $urandom; tv = $urandom;
         bus.fire_req = fr; bus.abort = ab; bus.target_angle = ta; bus.target_velocity = tv;
         e_ack = 0; e_done = 0; e_ab = 0;
         if (m_idle) begin
            if (fr && !ab) begin
               m_idle = 0; m_k = 0; m_cool_at = SL + PL + FL; m_abflag = 0;
               m_ang = ta; m_vel = tv; e_ack = 1;
            end
         end else begin
            if (ab && phase_of(m_k) != 4) begin
               m_cool_at = m_k + 1; m_abflag = 1; e_ab = 1;
            end
            m_k++;
            if (m_k == m_cool_at + CL) begin
               m_idle = 1; e_done = !m_abflag;
            end
         end
         if (m_idle) begin
            e_st = 3'd0; e_vo = 32'd0; e_sh = 0;
         end else begin
            ph = phase_of(m_k);
            e_st = 3'(ph);
            e_vo = (ph == 2 || ph == 3) ? m_vel : 32'd0;
            e_sh = (ph == 3);
         end
         step();
         check($sformatf("rand[%0d]", n),
               {bus.state, bus.busy, bus.shoot_enable, bus.fire_ack, bus.done, bus.aborted,
                bus.velocity_out, bus.angle_out},
               {e_st, !m_idle, e_sh, e_ack, e_done, e_ab, e_vo, m_ang});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
